// File: rtl/ahb_rst_pkg.sv
// Shared types for the AHB reset sequencer.
//   rst_state_e : sequencer FSM states (encoding is internal only)
//   rst_cause_e : value reported on rst_cause for the last reset
package ahb_rst_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } rst_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_EXT       = 2'd1,
    CAUSE_SW        = 2'd2,
    CAUSE_SW_FORCED = 2'd3
  } rst_cause_e;

endpackage

// File: rtl/ahb_rst_seq.sv
// Reset sequencer for the AHB subsystem.
// Stretches the synchronized reset and releases per-domain resets in index
// order (interconnect, masters, slaves), staggered in time. Software reset
// requests first drain the bus (wait for bus_idle, bounded by a timeout) and
// then run the same hold/release sequence.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (already synchronized)
//   sw_rst_req in   software reset request, honoured only in RUN
//   bus_idle   in   1 = no AHB transfer in flight
//   rst_out    out  per-domain active-high resets (registered)
//   rst_busy   out  1 while draining, holding or releasing (registered)
//   rst_cause  out  last reset cause, see rst_cause_e (sticky)
module ahb_rst_seq
  import ahb_rst_pkg::*;
#(
  parameter int NUM_DOMAINS    = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic                   bus_idle,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   rst_busy,
  output logic [1:0]             rst_cause
);

  // Count (relative to HOLD entry) at which the last domain is released.
  localparam int LAST_REL = HOLD_CYCLES + (NUM_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CNT_MAX  = (LAST_REL > DRAIN_TIMEOUT) ? LAST_REL : DRAIN_TIMEOUT;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LAST_C    = CW'(LAST_REL);
  localparam logic [CW-1:0] HOLD_C    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(DRAIN_TIMEOUT - 1);

  if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1 || DRAIN_TIMEOUT < 1)
  begin : g_bad_params
    $error("ahb_rst_seq: illegal parameter value");
  end

  rst_state_e            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic [NUM_DOMAINS-1:0] keep_mask;

  assign cnt_nxt = cnt + CW'(1);

  // Domain i stays in reset while the count after this edge is below its
  // release point; ANDing with the current value keeps releases one-way.
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      keep_mask[i] = (cnt_nxt < CW'(HOLD_CYCLES + i * STAGGER_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      rst_out   <= '1;
      rst_busy  <= 1'b1;
      rst_cause <= CAUSE_EXT;
    end else begin
      unique case (state)
        RUN: begin
          rst_out  <= '0;
          rst_busy <= 1'b0;
          if (sw_rst_req) begin
            state    <= DRAIN;
            cnt      <= '0;
            rst_busy <= 1'b1;
          end
        end

        // Idle takes precedence over the timeout on the same edge.
        DRAIN: begin
          if (bus_idle) begin
            state     <= HOLD;
            cnt       <= '0;
            rst_out   <= '1;
            rst_cause <= CAUSE_SW;
          end else if (cnt == TIMEOUT_C) begin
            state     <= HOLD;
            cnt       <= '0;
            rst_out   <= '1;
            rst_cause <= CAUSE_SW_FORCED;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        // HOLD and RELEASE share the count from HOLD entry; the last
        // release edge returns straight to RUN (covers NUM_DOMAINS=1).
        HOLD, RELEASE: begin
          cnt     <= cnt_nxt;
          rst_out <= rst_out & keep_mask;
          if (cnt_nxt == LAST_C) begin
            state    <= RUN;
            rst_busy <= 1'b0;
          end else if (state == HOLD && cnt_nxt == HOLD_C) begin
            state <= RELEASE;
          end
        end

        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rst_seq.sv
// Testbench for ahb_rst_seq: directed scenarios followed by random stimulus,
// all checked every cycle against a time-based reference model.
module tb_ahb_rst_seq;

  localparam int N       = 3;
  localparam int HOLD    = 16;
  localparam int STAG    = 4;
  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic         bus_idle = 1'b0;
  logic [N-1:0] rst_out;
  logic         rst_busy;
  logic [1:0]   rst_cause;

  int checks = 0;
  int errors = 0;

  ahb_rst_seq #(
    .NUM_DOMAINS(N), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .DRAIN_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .bus_idle(bus_idle),
    .rst_out(rst_out), .rst_busy(rst_busy), .rst_cause(rst_cause)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=running, 1=draining, 2=reset sequence.
  // Outputs follow from the edge index t relative to the HOLD entry h
  // or the drain start e.
  longint t = 0;
  longint h = 0;
  longint e = 0;
  int     mode = 0;
  int     m_cause = 0;
  bit     cause_known = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  task automatic model_step();
    t++;
    if (rst) begin
      mode = 2; h = t; m_cause = 1; cause_known = 1;
    end else begin
      case (mode)
        0: if (sw_rst_req) begin mode = 1; e = t; end
        1: begin
          if (bus_idle) begin mode = 2; h = t; m_cause = 2; end
          else if (t - e == TIMEOUT) begin mode = 2; h = t; m_cause = 3; end
        end
        default: if (t == h + HOLD + (N - 1) * STAG) mode = 0;
      endcase
    end
  endtask

  function automatic int exp_rst_out();
    int v = 0;
    if (mode == 2)
      for (int i = 0; i < N; i++)
        if (t < h + HOLD + i * STAG) v |= (1 << i);
    return v;
  endfunction

  // Drive inputs on the falling edge, step model and DUT on the rising
  // edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit req, input bit idle);
    @(negedge clk);
    rst = r; sw_rst_req = req; bus_idle = idle;
    @(posedge clk);
    model_step();
    #1;
    if (cause_known) begin
      check_val("rst_out", int'(rst_out), exp_rst_out());
      check_val("rst_busy", int'(rst_busy), (mode != 0) ? 1 : 0);
      check_val("rst_cause", int'(rst_cause), m_cause);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // External reset, 5 cycles, then full release sequence.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1);
    idle_cycles(30);

    // Software request with bus already idle.
    cyc(1'b0, 1'b1, 1'b1);
    idle_cycles(30);

    // Software request with bus never idle: forced by timeout.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) cyc(1'b0, 1'b0, 1'b0);
    idle_cycles(20);

    // Bus goes idle on DRAIN edge 30.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 29; i++) cyc(1'b0, 1'b0, 1'b0);
    idle_cycles(30);

    // Bus goes idle exactly on the timeout edge.
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b0, 1'b0);
    idle_cycles(30);

    // External reset pulsed right after domain 0 releases.
    cyc(1'b1, 1'b0, 1'b1);
    idle_cycles(HOLD);
    cyc(1'b1, 1'b0, 1'b1);
    idle_cycles(30);

    // Software request held through the whole sequence.
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'b1);
    idle_cycles(30);

    // Software request coinciding with external reset.
    cyc(1'b1, 1'b1, 1'b0);
    idle_cycles(30);

    // Random stimulus.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
